// File: rtl/filter_pkg.sv
// filter_pkg: shared constants for the filter-mode selector.
//   KEY_*  : index of each command key within the key vector.
//   MODE_* : encodings of the existing filter modes driven to the filter mux.
package filter_pkg;

    localparam int unsigned KEY_CLR  = 0;
    localparam int unsigned KEY_NEXT = 1;
    localparam int unsigned KEY_PREV = 2;
    localparam int unsigned KEY_LOCK = 3;

    localparam int unsigned MODE_BYPASS  = 0;
    localparam int unsigned MODE_BLUR    = 1;
    localparam int unsigned MODE_SHARPEN = 2;
    localparam int unsigned MODE_EDGE    = 3;

endpackage : filter_pkg

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser followed by a stability counter for one key.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous key input
//   level      : debounced level (registered)
//   rise       : high for one cycle after level goes 0 -> 1
module key_debounce #(
    parameter int unsigned DELAY_COUNTS = 2500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DELAY_COUNTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_COUNTS - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             level_q;

    // Synchronise, then accept the new level only after DELAY_COUNTS stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            level_q <= level;
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = level & ~level_q;

endmodule : key_debounce

// File: rtl/filter_mode_sel.sv
// filter_mode_sel: debounced key commands (clear/next/prev/lock) driving a
// wrapping filter-mode register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key          : raw active-high push-buttons (keys 0..3 are commands)
//   mode         : current filter mode
//   mode_changed : one-cycle pulse when mode takes a new value
//   locked       : next/prev blocked while high
//   key_level    : debounced key levels
// Optional feature: define FILTER_AUTOREPEAT_EN for hold-to-repeat on next/prev.
module filter_mode_sel
    import filter_pkg::*;
#(
    parameter  int unsigned NUM_KEYS      = 4,
    parameter  int unsigned NUM_MODES     = 4,
    parameter  int unsigned DELAY_COUNTS  = 2500,
    parameter  int unsigned REPEAT_COUNTS = 25_000_000,
    localparam int unsigned MODE_W        = $clog2(NUM_MODES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [MODE_W-1:0]   mode,
    output logic                mode_changed,
    output logic                locked,
    output logic [NUM_KEYS-1:0] key_level
);

    localparam int unsigned MODE_W1 = MODE_W + 1;

    // Parameter sanity checks at elaboration.
    if (NUM_KEYS < 4) begin : g_chk_keys
        $error("filter_mode_sel: NUM_KEYS must be >= 4");
    end
    if (NUM_MODES < 2 || NUM_MODES > 256) begin : g_chk_modes
        $error("filter_mode_sel: NUM_MODES must be in 2..256");
    end
    if (DELAY_COUNTS < 1 || REPEAT_COUNTS < 1) begin : g_chk_counts
        $error("filter_mode_sel: DELAY_COUNTS and REPEAT_COUNTS must be >= 1");
    end

    logic [NUM_KEYS-1:0] key_rise;
    logic                unused_rise;

    // One debouncer per key; keys above 3 are only reported on key_level.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DELAY_COUNTS(DELAY_COUNTS)
        ) u_key_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (key[i]),
            .level(key_level[i]),
            .rise (key_rise[i])
        );
    end

    assign unused_rise = ^key_rise;

    logic rep_next;
    logic rep_prev;

`ifdef FILTER_AUTOREPEAT_EN
    logic [31:0] hold_cnt;
    logic        hold_active;
    logic        rep_fire;

    // Repeat only while exactly one of next/prev is held and not locked.
    assign hold_active = (key_level[KEY_NEXT] ^ key_level[KEY_PREV]) & ~locked;
    assign rep_fire    = hold_active && (hold_cnt == 32'(REPEAT_COUNTS - 1));
    assign rep_next    = rep_fire & key_level[KEY_NEXT];
    assign rep_prev    = rep_fire & key_level[KEY_PREV];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!hold_active || rep_fire) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 32'd1;
        end
    end
`else
    assign rep_next = 1'b0;
    assign rep_prev = 1'b0;
`endif

    logic              step_next;
    logic              step_prev;
    logic [MODE_W:0]   mode_inc_w;
    logic [MODE_W:0]   mode_dec_w;
    logic [MODE_W-1:0] mode_inc;
    logic [MODE_W-1:0] mode_dec;
    logic [MODE_W-1:0] mode_d;
    logic              locked_d;

    // Command decode: clear beats everything, lock toggles alongside, next+prev cancel.
    always_comb begin
        mode_d     = mode;
        locked_d   = locked;
        step_next  = key_rise[KEY_NEXT] | rep_next;
        step_prev  = key_rise[KEY_PREV] | rep_prev;

        // Wrap checks done one bit wider so non-power-of-two counts work.
        mode_inc_w = {1'b0, mode} + MODE_W1'(1);
        mode_dec_w = {1'b0, mode} - MODE_W1'(1);
        mode_inc   = (mode_inc_w >= MODE_W1'(NUM_MODES)) ? '0 : mode_inc_w[MODE_W-1:0];
        mode_dec   = mode_dec_w[MODE_W] ? MODE_W'(NUM_MODES - 1) : mode_dec_w[MODE_W-1:0];

        if (key_rise[KEY_LOCK]) begin
            locked_d = ~locked;
        end
        if (key_rise[KEY_CLR]) begin
            mode_d = '0;
        end else if (!locked && (step_next ^ step_prev)) begin
            mode_d = step_next ? mode_inc : mode_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= '0;
            locked       <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode         <= mode_d;
            locked       <= locked_d;
            mode_changed <= (mode_d != mode);
        end
    end

endmodule : filter_mode_sel
